// File: rtl/spi_slave_stream.sv
// SPI slave that streams DATA_W-bit words under a single CS assertion.
// Received words appear as one-cycle strobes. Transmit words pass through a one-entry holding register.
module spi_slave_stream #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       CPOL        = 0,
  parameter int unsigned       CPHA        = 0,
  parameter int unsigned       LSB_FIRST   = 0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DEFAULT_TX  = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam int unsigned CNT_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned SET_W       = $clog2(SYNC_STAGES + 1);
  localparam logic        SCK_IDLE    = (CPOL != 0);
  localparam logic        SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SET_W-1:0]       settle;
  logic                   armed;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-2:0]      rx_shift;
  logic [DATA_W-1:0]      tx_shift;
  logic [DATA_W-1:0]      hold_data;

  logic              cs_s;
  logic              mosi_s;
  logic              sck_rise;
  logic              sck_fall;
  logic              sample_edge;
  logic              shift_edge;
  logic              enter;
  logic              leave;
  logic              do_sample;
  logic              do_shift;
  logic              do_load;
  logic              word_end;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_rot;
  logic [DATA_W-1:0] load_word;
  logic              load_bit;
  logic              rot_bit;

  // Pin synchronisers; bit 0 is the newest sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync   <= {SYNC_STAGES{1'b1}};
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      mosi_sync <= '0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sck_rise    = sck_sync[SYNC_STAGES-2] & ~sck_sync[SYNC_STAGES-1];
  assign sck_fall    = ~sck_sync[SYNC_STAGES-2] & sck_sync[SYNC_STAGES-1];
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

  assign enter     = (state == IDLE) && armed && !cs_s;
  assign leave     = (state == ACTIVE) && cs_s;
  assign do_sample = (state == ACTIVE) && !cs_s && sample_edge;
  assign do_shift  = (state == ACTIVE) && !cs_s && shift_edge;
  assign do_load   = (enter && (CPHA == 0)) || (do_shift && (bit_cnt == '0));
  assign word_end  = (bit_cnt == CNT_W'(DATA_W - 1));

  // rx_shift holds the DATA_W-1 bits collected so far in the current word
  assign rx_next   = (LSB_FIRST != 0) ? {mosi_s, rx_shift} : {rx_shift, mosi_s};
  assign tx_rot    = (LSB_FIRST != 0) ? {tx_shift[0], tx_shift[DATA_W-1:1]}
                                      : {tx_shift[DATA_W-2:0], tx_shift[DATA_W-1]};
  assign load_word = tx_ready ? DEFAULT_TX : hold_data;
  assign load_bit  = (LSB_FIRST != 0) ? load_word[0] : load_word[DATA_W-1];
  assign rot_bit   = (LSB_FIRST != 0) ? tx_rot[0] : tx_rot[DATA_W-1];

  // Frame FSM, datapath and holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      settle      <= '0;
      armed       <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold_data   <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b1;
      tx_underrun <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;

      // After reset, entry requires a settled CS that has been seen high
      if (settle != SET_W'(SYNC_STAGES)) begin
        settle <= settle + SET_W'(1);
      end else if (cs_s) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (enter) begin
            state   <= ACTIVE;
            miso_oe <= 1'b1;
          end
        end
        ACTIVE: begin
          if (leave) begin
            state       <= IDLE;
            miso_oe     <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            frame_done  <= (bit_cnt == '0);
            frame_abort <= (bit_cnt != '0);
          end else if (do_sample) begin
            if (word_end) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              rx_shift <= '0;
            end else begin
              bit_cnt  <= bit_cnt + CNT_W'(1);
              rx_shift <= (LSB_FIRST != 0) ? rx_next[DATA_W-1:1] : rx_next[DATA_W-2:0];
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (leave) begin
        tx_shift <= '0;
        miso     <= 1'b0;
      end else if (do_load) begin
        tx_shift <= load_word;
        miso     <= load_bit;
        if (tx_ready) begin
          tx_underrun <= 1'b1;
        end else begin
          tx_ready <= 1'b1;
        end
      end else if (do_shift) begin
        tx_shift <= tx_rot;
        miso     <= rot_bit;
      end

      // No bypass: a word written during an empty-register load waits for the next load
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        tx_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_slave_stream.md
Name: spi_slave_stream

Overview:
Parametrised SPI slave: configurable word width, SPI mode (CPOL/CPHA) and bit order; continuous multi-word frames under one CS assertion. Sits between the FPGA pins driven by the host MCU (ESP32 SPI master) and fabric logic. Presents received words as single-cycle strobes and accepts transmit words through a one-entry holding register with valid/ready. Flags underrun and aborted (partial-word) frames.

Parameters:
DATA_W, 8, bits per word (2..32)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on first SCK edge, 1 = sample on second edge
LSB_FIRST, 0, 0 = MSB first on both MOSI and MISO
SYNC_STAGES, 2, synchroniser depth on sck/cs/mosi (>=2)
DEFAULT_TX, {DATA_W{1'b1}}, word shifted out when holding register empty

Ports:
clk  in  1  system clock; must be >= 8x SCK frequency
rst  in  1  asynchronous, active-low reset
cs  in  1  chip select, active low, asynchronous to clk
sck  in  1  SPI clock, asynchronous
mosi  in  1  master out
miso  out  1  slave out (registered)
miso_oe  out  1  1 while CS active (pad tri-state control)
rx_data  out  DATA_W  last complete received word, held until next
rx_valid  out  1  one-cycle strobe: rx_data updated
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  write strobe into holding register
tx_ready  out  1  holding register empty
tx_underrun  out  1  one-cycle strobe: DEFAULT_TX loaded
frame_done  out  1  one-cycle strobe on CS deassertion, clean word boundary
frame_abort  out  1  one-cycle strobe on CS deassertion mid-word

Behaviour:
- Reset (rst=0, async): all outputs 0 except tx_ready=1; holding register empty; shift regs and counters 0; state IDLE; sync chains to idle values (cs=1, sck=CPOL, mosi=0).
- Synchronisation: SYNC_STAGES flops each on cs, sck, mosi; edges detected from last two stages of sck. mosi uses same depth, so sampled value aligns with sck edge.
- Sample edge = rising when CPOL==CPHA, else falling; shift edge = the opposite edge.
- States: IDLE -> ACTIVE on synced CS low; ACTIVE -> IDLE on synced CS high. Edges ignored in IDLE.
- Bit counter 0..DATA_W-1, incremented on each sample edge; wraps to 0 at word end.
- RX: on each sample edge shift in mosi (at LSB if MSB-first, at MSB if LSB_FIRST). On DATA_W-th sample: rx_data <= completed word, rx_valid=1 for exactly one clk, counter wraps. rx_valid asserted within SYNC_STAGES+2 clk of the pin edge. No backpressure; rx_data overwritten by next word.
- TX load event: CPHA=0 — the cycle ACTIVE is entered, and the first shift edge after a word completes. CPHA=1 — first shift edge of each word (counter==0).
- At load event: if holding register full, tx_shift <= holding word, holding empties (tx_ready=1 next cycle); else tx_shift <= DEFAULT_TX and tx_underrun pulses 1 cycle. miso takes the first bit the same cycle the load registers.
- Other shift edges: shift tx_shift, miso <= next bit (MSB-first or LSB-first per LSB_FIRST).
- Holding register: write when tx_valid && tx_ready; tx_valid while !tx_ready ignored (no overwrite). Write and load event in same cycle with register empty: the load uses DEFAULT_TX (underrun); the written word stays for the next load. No bypass.
- miso=0 and miso_oe=0 in IDLE.
- CS deassert: always flush counter, shift regs and miso. Flush occurs same cycle as synced CS rise. frame_done if counter==0, frame_abort otherwise; partial RX word discarded, no rx_valid. A loaded, partly shifted TX word is lost. Holding register contents retained.
- CS glitch shorter than SYNC_STAGES clk: may be ignored; no requirement.
- Reset mid-frame: immediate return to reset state; on release, waits for CS high before next entry to ACTIVE.

Test Plan:
- Mode 0, DATA_W=8: write 0xA5 before CS; master sends 0x3C -> rx_data=0x3C, one rx_valid pulse; master reads 0xA5; tx_ready back to 1 after load; frame_done pulse.
- Mode 0, 3-word frame: MOSI 0x01,0x02,0x03; bench refills on tx_ready with 0x10,0x20,0x30 -> three rx_valid pulses with 0x01/0x02/0x03; MISO 0x10,0x20,0x30; no underrun.
- Underrun: holding empty, DEFAULT_TX=0xFF -> master reads 0xFF, tx_underrun exactly one pulse. Write 0x5A mid-word -> next word reads 0x5A.
- CPOL=1, CPHA=1, LSB_FIRST=1, DATA_W=16: master sends 0xBEEF LSB-first; holding 0x1234 -> rx_data=0xBEEF; master receives 0x1234.
- Abort: CS high after 5 bits of 0xC3 -> no rx_valid, frame_abort pulse. Next frame sending 0x81 -> rx_data=0x81, frame_done.
- rst low mid-word (bit 4) with holding full -> all outputs reset, tx_ready=1, rx_valid never pulses. Following full frame operates normally.
